// File: rtl/bisqr_o_b_if.sv
// Stream interface for the bipolar squaring kernel: the input stream, the
// tap select, the squared output stream and the windowed ones-count estimate.
interface bisqr_o_b_if #(
    parameter int DEPLOG_SR = 2,
    parameter int CNT_W     = 8
);
    logic                 en;
    logic [DEPLOG_SR-1:0] randNum;
    logic                 in;
    logic                 out;
    logic [CNT_W:0]       est;
    logic                 est_valid;

    modport master (output en, randNum, in, input out, est, est_valid);
    modport slave  (input en, randNum, in, output out, est, est_valid);
endinterface

// File: rtl/bisqr_o_b.sv
// Bipolar unary-stream squarer: out = XNOR(in, decorrelated copy of in).
// The copy comes from an isolator shift register at a selectable tap, and a
// windowed ones-counter turns the output stream back into a binary estimate.
module bisqr_o_b #(
    parameter int DEP_SR    = 4,
    parameter int DEPLOG_SR = 2,
    parameter int CNT_W     = 8
) (
    input logic        clk,
    input logic        rst,
    bisqr_o_b_if.slave s
);
    logic [DEP_SR-1:0] sr;
    logic              tap;
    logic              out_q;
    logic [CNT_W-1:0]  win_cnt;
    logic [CNT_W:0]    ones_cnt;
    logic [CNT_W:0]    est_q;
    logic              est_vld_q;

    // Tap select; out-of-range selects fall back to the oldest bit, sr[0].
    always_comb begin
        tap = sr[0];
        for (int i = 1; i < DEP_SR; i++)
            if (s.randNum == DEPLOG_SR'(i))
                tap = sr[i];
    end

    // Isolator: new bits enter at the top, sr[k] is in delayed by DEP_SR-k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEP_SR; i++)
                sr[i] <= 1'(i % 2);
        end else if (s.en) begin
            sr <= {s.in, sr[DEP_SR-1:1]};
        end
    end

    // Bipolar multiply of the stream with its delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_q <= 1'b0;
        else if (s.en)
            out_q <= ~(s.in ^ tap);
    end

    // Window counter: count registered out over 2^CNT_W enabled cycles,
    // publish the total with a one-cycle valid pulse, then restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt   <= '0;
            ones_cnt  <= '0;
            est_q     <= '0;
            est_vld_q <= 1'b0;
        end else begin
            est_vld_q <= 1'b0;
            if (s.en) begin
                win_cnt <= win_cnt + 1'b1;
                if (win_cnt == {CNT_W{1'b1}}) begin
                    est_q     <= ones_cnt + {{CNT_W{1'b0}}, out_q};
                    est_vld_q <= 1'b1;
                    ones_cnt  <= '0;
                end else begin
                    ones_cnt  <= ones_cnt + {{CNT_W{1'b0}}, out_q};
                end
            end
        end
    end

    assign s.out       = out_q;
    assign s.est       = est_q;
    assign s.est_valid = est_vld_q;
endmodule
